float_less_stream: RTL and testbench
====================================

Name: float_less_stream

Overview:
- Pipelined, flow-controlled floating-point less-than comparator.
- Computes a < b under IEEE-754 rules, plus equal and unordered flags.
- Parameterised over half, single and double precision.
- Sits between operand producers and decision logic in the Precision datapath, where stalls must propagate as backpressure.

Parameters:
- BITS, 16, operand width. Must be 16 for "HALF", 32 for "SINGLE", 64 for "DOUBLE".
- PRECISION, "HALF", format select: "HALF" (exp 5, mant 10), "SINGLE" (exp 8, mant 23), "DOUBLE" (exp 11, mant 52).
- TAG_BITS, 4, width of the user tag carried alongside each operand pair.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept an operand pair this cycle
- in_a  in  BITS  operand a
- in_b  in  BITS  operand b
- in_tag  in  TAG_BITS  user tag, passed through unchanged
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_less  out  1  a < b
- out_equal  out  1  a == b
- out_unordered  out  1  a or b is NaN
- out_tag  out  TAG_BITS  tag of this result

Behaviour:
- Reset (async assert, release synchronous to clk): both stage-valid bits are 0, out_valid is 0, and all out_* data outputs are 0. Any transaction in flight when rst asserts is discarded and never emitted.
- Handshake:
  - An input transfer occurs when in_valid && in_ready at a clk edge.
  - An output transfer occurs when out_valid && out_ready at a clk edge.
  - out_* must hold stable while out_valid && !out_ready.
- Pipeline: two register stages, S1 then S2.
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv. This is combinational from out_ready, and is intentional.
  - out_valid = s2_valid.
- Latency: exactly 2 cycles from input transfer to out_valid when there are no stalls. Throughput is 1 result per cycle when out_ready is held high.
- Simultaneous events: if S2 is full, out_ready=1 and S1 is full, then S2 loads from S1, S1 loads a new input if one is offered, and nothing is lost or duplicated. In-order delivery is guaranteed.
- S1 registers, per operand:
  - sign
  - isnan: exponent all ones and mantissa != 0
  - iszero: exponent and mantissa both 0
  - magnitude compare of bits [BITS-2:0], as mag_lt and mag_eq
  - tag
- S2 computes and registers the result:
  - unordered = isnan_a || isnan_b. If unordered: less=0, equal=0.
  - Else if iszero_a && iszero_b: equal=1, less=0. This holds regardless of sign (+0 == -0).
  - Else if signs differ: less = sign_a, equal=0.
  - Else if both positive: less = mag_lt, equal = mag_eq.
  - Else (both negative): less = !mag_lt && !mag_eq, equal = mag_eq.
- Infinities and subnormals fall out of the magnitude compare naturally; no special path is needed.
- Exactly one of {less, equal, unordered, "greater"} is true for each result. "Greater" is implied when all three flags are 0.
- An unsupported PRECISION/BITS combination must fail elaboration via $error.

Test Plan:
- SINGLE, out_ready=1, back-to-back pairs (3F800000,40000000), (40000000,3F800000), (BF800000,C0000000) -> results 2, 3 and 4 cycles after the first transfer: less=1 / less=0 eq=0 / less=0 eq=0, with tags 0, 1, 2 preserved in order.
- SINGLE (00000000,80000000) -> equal=1, less=0. (7FC00000,3F800000) -> unordered=1, less=0, equal=0. (FF800000,7F800000) -> less=1.
- HALF, default parameters: (3C00,4000) -> less=1. (C000,BC00) -> less=1. (0001,0000) -> less=0 eq=0 (subnormal). (7C01,7C01) -> unordered=1.
- Backpressure: hold out_ready=0 while streaming 5 pairs -> exactly 2 accepted, then in_ready=0 and out_* stable. Release out_ready -> all 5 results emerge in order, none dropped or duplicated.
- Random out_ready/in_valid over 10k DOUBLE pairs against a $bitstoreal-based reference model with NaN/zero handling -> zero mismatches.
- Assert rst with 2 transactions in flight -> out_valid=0 and outputs 0 immediately. After release, the next pair's result is the first one emitted.

Source files
------------

// File: rtl/float_less_stream.sv
// Two-stage, ready/valid IEEE-754 less-than comparator with equal and unordered flags.
// S1 classifies both operands and compares magnitudes; S2 resolves sign/zero/NaN rules.
module float_less_stream #(
    parameter int    BITS      = 16,
    parameter string PRECISION = "HALF",
    parameter int    TAG_BITS  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BITS-1:0]     in_a,
    input  logic [BITS-1:0]     in_b,
    input  logic [TAG_BITS-1:0] in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_less,
    output logic                out_equal,
    output logic                out_unordered,
    output logic [TAG_BITS-1:0] out_tag
);

    localparam int EXP_W  = (PRECISION == "DOUBLE") ? 11 :
                            ((PRECISION == "SINGLE") ? 8 : 5);
    localparam int MANT_W = BITS - 1 - EXP_W;

    generate
        if (!((PRECISION == "HALF"   && BITS == 16) ||
              (PRECISION == "SINGLE" && BITS == 32) ||
              (PRECISION == "DOUBLE" && BITS == 64))) begin : g_bad_format
            $error("float_less_stream: unsupported PRECISION/BITS combination");
        end
    endgenerate

    function automatic logic f_is_nan(input logic [BITS-1:0] x);
        return (&x[BITS-2:MANT_W]) && (|x[MANT_W-1:0]);
    endfunction

    function automatic logic f_is_zero(input logic [BITS-1:0] x);
        return ~|x[BITS-2:0];
    endfunction

    // Result encoding {less, equal, unordered}; all-zero means greater.
    function automatic logic [2:0] f_decide(input logic sa, input logic sb,
                                            input logic na, input logic nb,
                                            input logic za, input logic zb,
                                            input logic lt, input logic eq);
        logic [2:0] r;
        r = 3'b000;
        if (na || nb)
            r = 3'b001;
        else if (za && zb)
            r = 3'b010;
        else if (sa != sb)
            r = {sa, 2'b00};
        else if (!sa)
            r = {lt, eq, 1'b0};
        else
            r = {!lt && !eq, eq, 1'b0};
        return r;
    endfunction

    logic                vld_p1, vld_p2;
    logic                adv_p1, adv_p2;
    logic                sign_a_p1, sign_b_p1;
    logic                nan_a_p1, nan_b_p1;
    logic                zero_a_p1, zero_b_p1;
    logic                mag_lt_p1, mag_eq_p1;
    logic [TAG_BITS-1:0] tag_p1;
    logic                less_p2, equal_p2, unord_p2;
    logic [TAG_BITS-1:0] tag_p2;
    logic [2:0]          decide;

    assign adv_p2   = !vld_p2 || out_ready;
    assign adv_p1   = !vld_p1 || adv_p2;
    assign in_ready = adv_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (adv_p1) vld_p1 <= in_valid;
            if (adv_p2) vld_p2 <= vld_p1;
        end
    end

    // Stage S1: operand classification and magnitude compare
    always_ff @(posedge clk) begin
        if (adv_p1 && in_valid) begin
            sign_a_p1 <= in_a[BITS-1];
            sign_b_p1 <= in_b[BITS-1];
            nan_a_p1  <= f_is_nan(in_a);
            nan_b_p1  <= f_is_nan(in_b);
            zero_a_p1 <= f_is_zero(in_a);
            zero_b_p1 <= f_is_zero(in_b);
            mag_lt_p1 <= in_a[BITS-2:0] < in_b[BITS-2:0];
            mag_eq_p1 <= in_a[BITS-2:0] == in_b[BITS-2:0];
            tag_p1    <= in_tag;
        end
    end

    assign decide = f_decide(sign_a_p1, sign_b_p1, nan_a_p1, nan_b_p1,
                             zero_a_p1, zero_b_p1, mag_lt_p1, mag_eq_p1);

    // Stage S2: result register; cleared on reset so idle outputs read zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            less_p2  <= 1'b0;
            equal_p2 <= 1'b0;
            unord_p2 <= 1'b0;
            tag_p2   <= '0;
        end else if (adv_p2 && vld_p1) begin
            less_p2  <= decide[2];
            equal_p2 <= decide[1];
            unord_p2 <= decide[0];
            tag_p2   <= tag_p1;
        end
    end

    assign out_valid     = vld_p2;
    assign out_less      = less_p2;
    assign out_equal     = equal_p2;
    assign out_unordered = unord_p2;
    assign out_tag       = tag_p2;

endmodule

// File: tb/tb_float_less_stream.sv
// Bench for float_less_stream: HALF, SINGLE and DOUBLE instances driven in lockstep,
// directed vector table, stream/backpressure/reset sequences and a random DOUBLE run.
module tb_float_less_stream;

    localparam int P_HALF = 0, P_SINGLE = 1, P_DOUBLE = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, out_ready;
    logic [63:0] a_drv, b_drv;
    logic [3:0]  tag_drv;
    int          sel;

    logic       ir_h, ov_h, lt_h, eq_h, un_h;
    logic       ir_s, ov_s, lt_s, eq_s, un_s;
    logic       ir_d, ov_d, lt_d, eq_d, un_d;
    logic [3:0] tg_h, tg_s, tg_d;

    logic       o_ready_in, o_valid, o_less, o_equal, o_unord;
    logic [3:0] o_tag;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    float_less_stream #(.BITS(16), .PRECISION("HALF"), .TAG_BITS(4)) dut_h (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_h),
        .in_a(a_drv[15:0]), .in_b(b_drv[15:0]), .in_tag(tag_drv),
        .out_valid(ov_h), .out_ready(out_ready), .out_less(lt_h),
        .out_equal(eq_h), .out_unordered(un_h), .out_tag(tg_h));

    float_less_stream #(.BITS(32), .PRECISION("SINGLE"), .TAG_BITS(4)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_s),
        .in_a(a_drv[31:0]), .in_b(b_drv[31:0]), .in_tag(tag_drv),
        .out_valid(ov_s), .out_ready(out_ready), .out_less(lt_s),
        .out_equal(eq_s), .out_unordered(un_s), .out_tag(tg_s));

    float_less_stream #(.BITS(64), .PRECISION("DOUBLE"), .TAG_BITS(4)) dut_d (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_d),
        .in_a(a_drv), .in_b(b_drv), .in_tag(tag_drv),
        .out_valid(ov_d), .out_ready(out_ready), .out_less(lt_d),
        .out_equal(eq_d), .out_unordered(un_d), .out_tag(tg_d));

    always_comb begin
        o_ready_in = ir_d; o_valid = ov_d; o_less = lt_d;
        o_equal = eq_d; o_unord = un_d; o_tag = tg_d;
        if (sel == P_HALF) begin
            o_ready_in = ir_h; o_valid = ov_h; o_less = lt_h;
            o_equal = eq_h; o_unord = un_h; o_tag = tg_h;
        end else if (sel == P_SINGLE) begin
            o_ready_in = ir_s; o_valid = ov_s; o_less = lt_s;
            o_equal = eq_s; o_unord = un_s; o_tag = tg_s;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: NaN by bit pattern, otherwise native real comparison.
    function automatic logic [2:0] ref_cmp(input logic [63:0] a, input logic [63:0] b);
        logic na, nb;
        real  ra, rb;
        na = (&a[62:52]) && (|a[51:0]);
        nb = (&b[62:52]) && (|b[51:0]);
        if (na || nb) return 3'b001;
        ra = $bitstoreal(a);
        rb = $bitstoreal(b);
        return {ra < rb, ra == rb, 1'b0};
    endfunction

    function automatic logic [63:0] rnd_special();
        logic [63:0] v;
        case ($urandom_range(0, 7))
            0: v = 64'h0000000000000000;
            1: v = 64'h8000000000000000;
            2: v = 64'h7FF0000000000000;
            3: v = 64'hFFF0000000000000;
            4: v = 64'h7FF8000000000000;
            5: v = 64'h0000000000000001;
            6: v = 64'h8000000000000001;
            default: v = 64'h3FF0000000000000;
        endcase
        return v;
    endfunction

    task automatic gen_pair(output logic [63:0] a, output logic [63:0] b);
        a = {$urandom, $urandom};
        b = a;
        case ($urandom_range(0, 5))
            0: b = {$urandom, $urandom};
            1: begin a = rnd_special(); b = rnd_special(); end
            2: b = a;
            3: b = a ^ 64'h8000000000000000;
            4: b = a ^ {54'd0, 10'($urandom)};
            default: begin a = rnd_special(); b = {$urandom, $urandom}; end
        endcase
    endtask

    task automatic run_vec(input string name, input int p, input logic [63:0] a,
                           input logic [63:0] b, input logic [3:0] tag, input logic [2:0] exp);
        int   n;
        logic ok;
        sel = p;
        out_ready = 1'b1;
        @(posedge clk); #1;
        a_drv = a; b_drv = b; tag_drv = tag; in_valid = 1'b1;
        n = 0; ok = 1'b0;
        while (!ok && n < 20) begin
            @(negedge clk);
            ok = o_ready_in;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        check({name, "_accept"}, ok, 1'b1);
        n = 0; ok = 1'b0;
        while (!ok && n < 20) begin
            @(negedge clk);
            if (o_valid) ok = 1'b1; else n++;
        end
        check({name, "_valid"}, ok, 1'b1);
        check(name, {o_less, o_equal, o_unord, o_tag}, {exp, tag});
    endtask

    typedef struct {
        int          p;
        logic [63:0] a;
        logic [63:0] b;
        logic [2:0]  exp;
    } vec_t;

    vec_t vecs[14];

    task automatic run_stream();
        sel = P_SINGLE;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1; a_drv = 64'h3F800000; b_drv = 64'h40000000; tag_drv = 4'd0;
        @(posedge clk); #1;
        a_drv = 64'h40000000; b_drv = 64'h3F800000; tag_drv = 4'd1;
        @(negedge clk);
        check("b2b_latency", o_valid, 1'b0);
        @(posedge clk); #1;
        a_drv = 64'hBF800000; b_drv = 64'hC0000000; tag_drv = 4'd2;
        @(negedge clk);
        check("b2b_r0", {o_valid, o_less, o_equal, o_unord, o_tag}, {4'b1100, 4'd0});
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b_r1", {o_valid, o_less, o_equal, o_unord, o_tag}, {4'b1000, 4'd1});
        @(posedge clk);
        @(negedge clk);
        check("b2b_r2", {o_valid, o_less, o_equal, o_unord, o_tag}, {4'b1000, 4'd2});
        @(posedge clk);
        @(negedge clk);
        check("b2b_drain", o_valid, 1'b0);
    endtask

    task automatic run_backpressure();
        int         acc, got;
        logic       irs, ovs;
        logic [6:0] res, held;
        sel = P_SINGLE;
        out_ready = 1'b0;
        acc = 0; got = 0; held = '0;
        @(posedge clk); #1;
        for (int c = 0; c < 60 && got < 5; c++) begin
            if (acc < 5) begin
                in_valid = 1'b1;
                a_drv = (acc % 2 == 0) ? 64'h3F800000 : 64'h40000000;
                b_drv = (acc % 2 == 0) ? 64'h40000000 : 64'h3F800000;
                tag_drv = 4'(acc + 8);
            end else begin
                in_valid = 1'b0;
            end
            if (c == 10) out_ready = 1'b1;
            @(negedge clk);
            irs = o_ready_in; ovs = o_valid;
            res = {o_less, o_equal, o_unord, o_tag};
            if (c == 2) held = res;
            if (c == 9) begin
                check("bp_accepted", 64'(acc), 64'd2);
                check("bp_in_ready", irs, 1'b0);
                check("bp_out_valid", ovs, 1'b1);
                check("bp_stable", res, held);
            end
            @(posedge clk);
            if (in_valid && irs) acc++;
            if (ovs && out_ready) begin
                check($sformatf("bp_result%0d", got), res,
                      {(got % 2 == 0), 2'b00, 4'(got + 8)});
                got++;
            end
            #1;
        end
        in_valid = 1'b0;
        check("bp_count", 64'(got), 64'd5);
        @(negedge clk);
        check("bp_no_dup", o_valid, 1'b0);
    endtask

    task automatic run_reset();
        sel = P_SINGLE;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1; a_drv = 64'h3F800000; b_drv = 64'h40000000; tag_drv = 4'd5;
        @(posedge clk); #1;
        tag_drv = 4'd6;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_pre_valid", {o_valid, o_less, o_tag}, {2'b11, 4'd5});
        #2 rst = 1'b1;
        #1;
        check("rst_async_out", {o_valid, o_less, o_equal, o_unord, o_tag}, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("rst_no_stale", o_valid, 1'b0);
        run_vec("rst_first", P_SINGLE, 64'h40000000, 64'h3F800000, 4'd9, 3'b000);
    endtask

    task automatic run_random(input int n);
        logic [6:0] exp_q[$];
        logic [6:0] res, e;
        logic       irs, ovs;
        int         sent, got, cyc;
        sel = P_DOUBLE;
        sent = 0; got = 0; cyc = 0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (got < n && cyc < 60000) begin
            if (!in_valid && sent < n && $urandom_range(0, 4) != 0) begin
                gen_pair(a_drv, b_drv);
                tag_drv = sent[3:0];
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            irs = o_ready_in; ovs = o_valid;
            res = {o_less, o_equal, o_unord, o_tag};
            @(posedge clk);
            if (ovs && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rnd_extra", ovs, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("rnd%0d", got), res, e);
                end
                got++;
            end
            if (in_valid && irs) begin
                exp_q.push_back({ref_cmp(a_drv, b_drv), tag_drv});
                sent++;
                #1 in_valid = 1'b0;
            end else begin
                #1;
            end
            cyc++;
        end
        in_valid = 1'b0;
        check("rnd_count", 64'(got), 64'(n));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{P_HALF,   64'h3C00, 64'h4000, 3'b100};
        vecs[1]  = '{P_HALF,   64'hC000, 64'hBC00, 3'b100};
        vecs[2]  = '{P_HALF,   64'h0001, 64'h0000, 3'b000};
        vecs[3]  = '{P_HALF,   64'h7C01, 64'h7C01, 3'b001};
        vecs[4]  = '{P_HALF,   64'h8000, 64'h0000, 3'b010};
        vecs[5]  = '{P_HALF,   64'hFC00, 64'hFBFF, 3'b100};
        vecs[6]  = '{P_SINGLE, 64'h00000000, 64'h80000000, 3'b010};
        vecs[7]  = '{P_SINGLE, 64'h7FC00000, 64'h3F800000, 3'b001};
        vecs[8]  = '{P_SINGLE, 64'hFF800000, 64'h7F800000, 3'b100};
        vecs[9]  = '{P_SINGLE, 64'h7F800000, 64'h7F7FFFFF, 3'b000};
        vecs[10] = '{P_DOUBLE, 64'h3FF0000000000000, 64'h4000000000000000, 3'b100};
        vecs[11] = '{P_DOUBLE, 64'hFFF0000000000000, 64'hFFF0000000000000, 3'b010};
        vecs[12] = '{P_DOUBLE, 64'h8000000000000001, 64'h0000000000000000, 3'b100};
        vecs[13] = '{P_DOUBLE, 64'h7FF0000000000001, 64'h0000000000000000, 3'b001};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a_drv = '0; b_drv = '0; tag_drv = '0; sel = P_DOUBLE;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_half",   {ir_h, ov_h, lt_h, eq_h, un_h, tg_h}, {5'b10000, 4'd0});
        check("reset_single", {ir_s, ov_s, lt_s, eq_s, un_s, tg_s}, {5'b10000, 4'd0});
        check("reset_double", {ir_d, ov_d, lt_d, eq_d, un_d, tg_d}, {5'b10000, 4'd0});
        rst = 1'b0;

        for (int i = 0; i < 14; i++)
            run_vec($sformatf("vec%0d", i), vecs[i].p, vecs[i].a, vecs[i].b, 4'(i), vecs[i].exp);

        run_stream();
        run_backpressure();
        run_reset();
        run_random(10000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
